// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and constants for the dmem two-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  // Burst counter wide enough for MAX_BURST up to 15
  localparam int BURST_W = 4;

  // Statistics counter width and saturation value
  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  typedef enum logic {
    OWNER_P0 = 1'b0,
    OWNER_P1 = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_P0 = 2'd1,
    ST_OWN_P1 = 2'd2
  } state_e;

  // Increment that sticks at the given limit
  function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v,
                                                 input logic [BURST_W-1:0] lim);
    return (v >= lim) ? lim : v + BURST_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_stats.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_stats
// Purpose  : Saturating grant/conflict counters for the dmem arbiter.
//            Only instantiated when DMEM_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arb_stats
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt0,
  input  logic              gnt1,
  input  logic              conflict,
  output logic [STAT_W-1:0] stat_gnt0,
  output logic [STAT_W-1:0] stat_gnt1,
  output logic [STAT_W-1:0] stat_conflict
);

  logic [STAT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
  logic [STAT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;
  logic [STAT_W-1:0] conf_cnt_q, conf_cnt_d;

  // Next counter values: count events, stop at all-ones
  always_comb begin
    gnt0_cnt_d = gnt0_cnt_q;
    gnt1_cnt_d = gnt1_cnt_q;
    conf_cnt_d = conf_cnt_q;
    if (gnt0 && (gnt0_cnt_q != STAT_MAX)) gnt0_cnt_d = gnt0_cnt_q + STAT_W'(1);
    if (gnt1 && (gnt1_cnt_q != STAT_MAX)) gnt1_cnt_d = gnt1_cnt_q + STAT_W'(1);
    if (conflict && (conf_cnt_q != STAT_MAX)) conf_cnt_d = conf_cnt_q + STAT_W'(1);
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      gnt0_cnt_q <= gnt0_cnt_d;
      gnt1_cnt_q <= gnt1_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign stat_gnt0     = gnt0_cnt_q;
  assign stat_gnt1     = gnt1_cnt_q;
  assign stat_conflict = conf_cnt_q;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter in front of the single-port dmem syncram.
//            Port 0 = processor load/store, port 1 = debug/loader.
//            Round-robin ownership with a bounded burst under contention.
//            Optional statistics counters: define DMEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_gnt0,
  output logic [STAT_W-1:0] stat_gnt1,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 p0_rvalid_q, p0_rvalid_d;
  logic                 p1_rvalid_q, p1_rvalid_d;

  logic                 both_req;
  logic                 any_gnt;
  owner_e               winner;
  logic [BURST_W-1:0]   eff_cnt;

  // Combinational arbitration from registered ownership plus live requests
  always_comb begin
    both_req = p0_req & p1_req;
    // The burst count only means something while a port holds ownership
    eff_cnt  = (state_q == ST_IDLE) ? '0 : burst_cnt_q;
    any_gnt  = reset & (p0_req | p1_req);
    winner   = owner_q;
    if (both_req) begin
      winner = (eff_cnt < MAX_CNT) ? owner_q : owner_e'(~owner_q);
    end else if (p0_req) begin
      winner = OWNER_P0;
    end else if (p1_req) begin
      winner = OWNER_P1;
    end
    p0_gnt = any_gnt & (winner == OWNER_P0);
    p1_gnt = any_gnt & (winner == OWNER_P1);
  end

  // Memory-side mux; held at zero while in reset
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (reset) begin
      if (winner == OWNER_P1) begin
        mem_address = p1_addr;
        mem_data    = p1_data;
        mem_wren    = any_gnt & p1_wren;
      end else begin
        mem_address = p0_addr;
        mem_data    = p0_data;
        mem_wren    = any_gnt & p0_wren;
      end
    end
  end

  // Next ownership, burst count and read-valid pipeline
  always_comb begin
    state_d     = ST_IDLE;
    owner_d     = owner_q;
    burst_cnt_d = '0;
    if (any_gnt) begin
      state_d = (winner == OWNER_P1) ? ST_OWN_P1 : ST_OWN_P0;
      if (winner == owner_q) begin
        burst_cnt_d = sat_inc(eff_cnt, MAX_CNT);
      end else begin
        owner_d     = winner;
        burst_cnt_d = BURST_W'(1);
      end
    end
    p0_rvalid_d = p0_gnt & ~p0_wren;
    p1_rvalid_d = p1_gnt & ~p1_wren;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_P0;
      burst_cnt_q <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign rdata     = mem_q;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk           (clock),
    .rst_n         (reset),
    .gnt0          (p0_gnt),
    .gnt1          (p1_gnt),
    .conflict      (both_req),
    .stat_gnt0     (stat_gnt0),
    .stat_gnt1     (stat_gnt1),
    .stat_conflict (stat_conflict)
  );
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port dmem syncram between two requesters. Port 0 is the processor load/store port; port 1 is a debug/loader port that preloads and inspects data memory.
Grants at most one access per cycle. Ownership is round-robin with a bounded burst: under contention the current owner keeps the memory for up to MAX_BURST consecutive accesses, then must yield.
Sits between the processor/debug logic and dmem in the top-level skeleton.

Parameters:
ADDR_W, 12, dmem word address width
DATA_W, 32, dmem data width
MAX_BURST, 4, max consecutive grants to the owner while the other port is requesting (1..15)

Ports:
clock  in  1  single clock; dmem is driven from the same clock
reset  in  1  asynchronous, active-low reset
p0_req  in  1  port 0 access request, held until granted
p0_wren  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 address
p0_data  in  DATA_W  port 0 write data
p0_gnt  out  1  port 0 access accepted this cycle
p0_rvalid  out  1  port 0 read data valid on rdata
p1_req, p1_wren, p1_addr, p1_data, p1_gnt, p1_rvalid  same as port 0, for port 1
rdata  out  DATA_W  read data, passthrough of mem_q
mem_address  out  ADDR_W  to dmem address
mem_data  out  DATA_W  to dmem data
mem_wren  out  1  to dmem write enable
mem_q  in  DATA_W  from dmem q (registered, 1-cycle read latency)

Behaviour:
- State: owner (P0/P1) and burst_cnt (0..MAX_BURST). FSM states:
  - IDLE: no grant in the previous cycle.
  - OWN_P0 / OWN_P1: last grant went to that port.
- Reset values (reset low): owner=P0, burst_cnt=0, state IDLE, p0_rvalid=p1_rvalid=0.
- While reset is low: p0_gnt=p1_gnt=0, mem_wren=0. mem_address and mem_data are don't-care but held at 0.
- Grant is combinational, same cycle as req, from registered state plus the current reqs:
  - Only one port requesting: that port wins.
  - Both requesting, burst_cnt<MAX_BURST: owner wins.
  - Both requesting, burst_cnt==MAX_BURST: the non-owner wins.
  - Neither requesting: no grant.
- State update on each clock edge:
  - Grant to owner: burst_cnt increments, saturating at MAX_BURST.
  - Grant to non-owner: owner switches, burst_cnt=1.
  - No grant: burst_cnt=0, owner retained, state IDLE.
- Memory drive: mem_address, mem_data and mem_wren are muxed from the winner. mem_wren = winner_wren & gnt. With no grant: mem_wren=0, mux selects owner.
- Read response: px_rvalid is registered and asserted exactly 1 cycle after a granted read (wren=0) by port x. rdata = mem_q in that cycle. Writes produce no rvalid.
- Back-to-back reads by the same port are allowed every cycle: one rvalid per grant, in order.
- A requester must hold req, wren, addr and data stable until gnt. Deasserting req before gnt abandons the request; nothing is issued.
- A single requester gets a grant every cycle regardless of MAX_BURST. Yielding only happens under contention.
- Reset asserted mid-operation clears any pending rvalid immediately (asynchronous). An in-flight write already clocked into dmem is not undone.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds outputs stat_gnt0[15:0], stat_gnt1[15:0] and stat_conflict[15:0].
  - stat_gnt0 / stat_gnt1 count grants per port.
  - stat_conflict counts cycles with both reqs asserted.
  - All counters saturate at 16'hFFFF and clear on reset.
- Not defined: the ports and logic are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package dmem_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - Owner encoding: P0=1'b0, P1=1'b1.
  - FSM state encoding: IDLE, OWN_P0, OWN_P1.
  - Counter width 16.
- Sub-module dmem_arb_stats holds the three saturating counters. It is instantiated only under DMEM_ARB_STATS_EN.

Test Plan:
- Reset: hold reset=0 with p0_req=1, p0_wren=1 -> p0_gnt=0, mem_wren=0. After release, first p0_req is granted the same cycle.
- Write/read on p1: p1 writes 0xDEADBEEF to 0x010 (p1_gnt=1, mem_wren=1, mem_address=0x010). Next cycle p1 reads 0x010 -> cycle after, p1_rvalid=1 and rdata=0xDEADBEEF; p0_rvalid stays 0.
- Contention, MAX_BURST=4: both reqs held from reset -> grant sequence P0,P0,P0,P0,P1,P1,P1,P1,P0.
- Ownership retention: p1 owns with burst_cnt=2, one idle cycle, then both request -> P1 wins with burst_cnt=1, yields to P0 after 4 grants.
- Reset mid-read: p0 read granted, reset pulled low in the next cycle before the edge -> p0_rvalid=0 immediately, state IDLE, owner=P0.
- Stats (macro on): 10 cycles of dual requests with MAX_BURST=1 -> stat_gnt0=5, stat_gnt1=5, stat_conflict=10.
